// File: rtl/bsg_dramsim3_traffic_gen.sv
// Single-channel DRAM traffic generator: writes an address-derived pattern, reads it back
// and checks each response by its returned address, so responses may arrive in any order.
module bsg_dramsim3_traffic_gen #(
   parameter int unsigned channel_addr_width_p = 29,
   parameter int unsigned data_width_p         = 256,
   parameter int unsigned num_reqs_p           = 64,
   parameter int unsigned base_addr_p          = 0,
   parameter int unsigned stride_p             = data_width_p / 8,
   parameter int unsigned max_outstanding_p    = 8,
   parameter logic [31:0] seed_p               = 32'h5a5a0000,
   localparam int unsigned CntW = $clog2(num_reqs_p + 1),
   localparam int unsigned OstW = $clog2(max_outstanding_p + 1)
) (
   input  logic                            clk_i,
   input  logic                            reset_n_i,
   input  logic                            start_i,
   output logic                            v_o,
   output logic                            write_not_read_o,
   output logic [channel_addr_width_p-1:0] ch_addr_o,
   input  logic                            yumi_i,
   output logic                            data_v_o,
   output logic [data_width_p-1:0]         data_o,
   output logic [data_width_p/8-1:0]       mask_o,
   input  logic                            data_yumi_i,
   input  logic                            data_v_i,
   input  logic [data_width_p-1:0]         data_i,
   input  logic [channel_addr_width_p-1:0] read_done_ch_addr_i,
   output logic                            done_o,
   output logic                            error_o,
   output logic [15:0]                     error_count_o,
   output logic [CntW-1:0]                 write_count_o,
   output logic [CntW-1:0]                 read_count_o
);

   localparam int unsigned AW = channel_addr_width_p;
   localparam int unsigned DW = data_width_p;
   localparam logic [CntW-1:0] LastIdx  = CntW'(num_reqs_p - 1);
   localparam logic [CntW-1:0] NumReqs  = CntW'(num_reqs_p);
   localparam logic [OstW-1:0] MaxOst   = OstW'(max_outstanding_p);
   localparam logic [AW-1:0]   BaseAddr = AW'(base_addr_p);
   localparam logic [AW-1:0]   Stride   = AW'(stride_p);

   typedef enum logic [2:0] {StIdle, StWrite, StRead, StDrain, StDone} state_e;

   state_e          state_q;
   logic [CntW-1:0] idx_q, wcnt_q, rcnt_q;
   logic [OstW-1:0] ost_q;
   logic [15:0]     ecnt_q;
   logic            err_q, done_q, v_q, wnr_q, dv_q;
   logic [AW-1:0]   addr_q;
   logic [DW-1:0]   data_q;

   function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a);
      logic [DW-1:0] p;
      logic [31:0]   a32;
      p   = '0;
      a32 = 32'(a);
      for (int k = 0; k < int'(DW / 32); k++) p[k*32 +: 32] = a32 ^ (seed_p + 32'(k));
      return p;
   endfunction

   logic            accept, issue, resp, resp_ok;
   logic [2:0]      n_err;
   logic [16:0]     ecnt_sum;
   logic [15:0]     ecnt_d;
   logic [CntW-1:0] rcnt_inc;
   logic [OstW-1:0] ost_next;
   logic [AW-1:0]   addr_nxt;

   // Responses are only meaningful once a run has started; stale ones in idle are dropped.
   always_comb begin
      accept   = v_q & yumi_i;
      issue    = accept & (state_q == StRead);
      resp     = data_v_i & (state_q != StIdle);
      resp_ok  = resp & (ost_q != '0);
      n_err    = 3'(yumi_i & ~v_q)
               + 3'((state_q == StWrite) & data_yumi_i & ~yumi_i)
               + 3'(resp & (data_i != pattern(read_done_ch_addr_i)))
               + 3'(resp & (ost_q == '0));
      ecnt_sum = {1'b0, ecnt_q} + 17'(n_err);
      ecnt_d   = ecnt_sum[16] ? 16'hffff : ecnt_sum[15:0];
      rcnt_inc = rcnt_q + CntW'(resp);
      ost_next = ost_q + OstW'(issue) - OstW'(resp_ok);
      addr_nxt = addr_q + Stride;
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= StIdle;
         idx_q   <= '0;
         wcnt_q  <= '0;
         rcnt_q  <= '0;
         ost_q   <= '0;
         ecnt_q  <= '0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
         v_q     <= 1'b0;
         wnr_q   <= 1'b0;
         dv_q    <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         ecnt_q <= ecnt_d;
         err_q  <= err_q | (n_err != '0);
         rcnt_q <= rcnt_inc;
         ost_q  <= ost_next;
         unique case (state_q)
            StIdle, StDone: begin
               if (start_i) begin
                  state_q <= StWrite;
                  idx_q   <= '0;
                  wcnt_q  <= '0;
                  rcnt_q  <= '0;
                  ost_q   <= '0;
                  ecnt_q  <= '0;
                  err_q   <= 1'b0;
                  done_q  <= 1'b0;
                  v_q     <= 1'b1;
                  wnr_q   <= 1'b1;
                  dv_q    <= 1'b1;
                  addr_q  <= BaseAddr;
                  data_q  <= pattern(BaseAddr);
               end
            end
            StWrite: begin
               if (accept) begin
                  wcnt_q <= wcnt_q + 1'b1;
                  if (idx_q == LastIdx) begin
                     state_q <= StRead;
                     idx_q   <= '0;
                     addr_q  <= BaseAddr;
                     wnr_q   <= 1'b0;
                     dv_q    <= 1'b0;
                     v_q     <= (ost_next < MaxOst);
                  end else begin
                     idx_q  <= idx_q + 1'b1;
                     addr_q <= addr_nxt;
                     data_q <= pattern(addr_nxt);
                  end
               end
            end
            StRead: begin
               if (accept && idx_q == LastIdx) begin
                  state_q <= StDrain;
                  v_q     <= 1'b0;
               end else begin
                  if (accept) begin
                     idx_q  <= idx_q + 1'b1;
                     addr_q <= addr_nxt;
                  end
                  v_q <= (ost_next < MaxOst);
               end
            end
            StDrain: begin
               if (rcnt_inc >= NumReqs) begin
                  state_q <= StDone;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign v_o              = v_q;
   assign write_not_read_o = wnr_q;
   assign ch_addr_o        = addr_q;
   assign data_v_o         = dv_q;
   assign data_o           = data_q;
   assign mask_o           = '1;
   assign done_o           = done_q;
   assign error_o          = err_q;
   assign error_count_o    = ecnt_q;
   assign write_count_o    = wcnt_q;
   assign read_count_o     = rcnt_q;

endmodule

// File: tb/tb_bsg_dramsim3_traffic_gen.sv
// Randomised bench for bsg_dramsim3_traffic_gen: a responder with variable acceptance,
// latency and return order, checked every cycle against a transaction-count model.
module tb_bsg_dramsim3_traffic_gen;

   localparam int AW = 8, DW = 64, N = 12, BASE = 64, STRIDE = 32, MAXO = 3;
   localparam int CW = $clog2(N + 1);
   localparam logic [31:0] SEED = 32'h5a5a0000;

   logic clk = 1'b0, reset_n = 1'b0, start = 1'b0;
   logic yumi = 1'b0, dyumi = 1'b0, rv = 1'b0;
   logic v, wnr, dv, done, err;
   logic [AW-1:0] addr, raddr = '0;
   logic [DW-1:0] wdata, rdata = '0;
   logic [DW/8-1:0] mask;
   logic [15:0] ecnt;
   logic [CW-1:0] wcnt, rcnt;

   always #5 clk = ~clk;

   bsg_dramsim3_traffic_gen #(
      .channel_addr_width_p(AW), .data_width_p(DW), .num_reqs_p(N), .base_addr_p(BASE),
      .stride_p(STRIDE), .max_outstanding_p(MAXO), .seed_p(SEED)
   ) dut (
      .clk_i(clk), .reset_n_i(reset_n), .start_i(start), .v_o(v), .write_not_read_o(wnr),
      .ch_addr_o(addr), .yumi_i(yumi), .data_v_o(dv), .data_o(wdata), .mask_o(mask),
      .data_yumi_i(dyumi), .data_v_i(rv), .data_i(rdata), .read_done_ch_addr_i(raddr),
      .done_o(done), .error_o(err), .error_count_o(ecnt), .write_count_o(wcnt),
      .read_count_o(rcnt)
   );

   int vectors = 0, miscompares = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [AW-1:0] addr_of(input int i);
      return AW'((BASE + i * STRIDE) % (1 << AW));
   endfunction

   function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
      logic [DW-1:0] p;
      for (int k = 0; k < DW / 32; k++) p[32*k +: 32] = {24'h0, a} ^ (SEED + 32'(k));
      return p;
   endfunction

   // Model: everything follows from how many writes/reads have been accepted and answered.
   bit m_active = 0;
   int m_wacc = 0, m_rissue = 0, m_rrecv = 0, m_out = 0, m_err = 0;
   bit wph, rph, m_done;
   int e;

   typedef struct {logic [AW-1:0] a; int due;} rd_t;
   rd_t pend[$];
   rd_t r;
   logic [DW-1:0] mem [logic [AW-1:0]];
   int cyc = 0, yumi_pct = 100, lat_min = 1, lat_max = 1, order_mode = 0, hold_left = 0;
   bit hold_mode = 0, inj_dyumi = 0, inj_yumi = 0, corrupt_next = 0, drop_pending = 0;

   always @(negedge clk) begin
      if (!reset_n) begin
         m_active = 0; m_wacc = 0; m_rissue = 0; m_rrecv = 0; m_out = 0; m_err = 0;
         check("rst v_o", v, 0);
         check("rst done_o", done, 0);
         check("rst error_count_o", ecnt, 0);
      end else begin
         wph    = m_active && m_wacc < N;
         rph    = m_active && m_wacc >= N && m_rissue < N;
         m_done = m_active && m_rissue >= N && m_rrecv >= N;
         check("v_o", v, wph ? 1 : rph ? 64'(m_out < MAXO) : 0);
         check("write_not_read_o", wnr, 64'(wph));
         check("data_v_o", dv, 64'(wph));
         check("mask_o", mask, 8'hff);
         if (wph) begin
            check("write addr", addr, addr_of(m_wacc));
            check("write data", wdata, pat(addr_of(m_wacc)));
         end
         if (rph && v) check("read addr", addr, addr_of(m_rissue));
         check("write_count_o", wcnt, 64'(m_wacc));
         check("read_count_o", rcnt, 64'(m_rrecv));
         check("error_count_o", ecnt, 64'(m_err));
         check("error_o", err, 64'(m_err != 0));
         check("done_o", done, 64'(m_done));
         if (yumi && v && wnr) mem[addr] = wdata;
         if (yumi && v && !wnr) begin
            r.a = addr;
            r.due = cyc + int'($urandom_range(lat_max, lat_min));
            pend.push_back(r);
         end
         if (start && (!m_active || m_done)) begin
            m_active = 1; m_wacc = 0; m_rissue = 0; m_rrecv = 0; m_out = 0; m_err = 0;
         end else begin
            e = 0;
            if (yumi && !v) e++;
            if (wph && dyumi && !yumi) e++;
            if (m_active && rv) begin
               if (rdata !== pat(raddr)) e++;
               if (m_out == 0) e++;
               else m_out--;
               m_rrecv++;
            end
            if (yumi && v) begin
               if (wph) m_wacc++;
               else if (rph) begin m_rissue++; m_out++; end
            end
            m_err = (m_err + e > 16'hffff) ? 16'hffff : m_err + e;
         end
      end
   end

   int pick, ndue, sel;
   always @(posedge clk) begin
      #1;
      cyc++;
      if (drop_pending) begin pend.delete(); drop_pending = 0; end
      yumi = 0; dyumi = 0; rv = 0;
      if (inj_yumi) begin
         yumi = 1; inj_yumi = 0;
      end else if (v) begin
         if (hold_mode && wnr && wcnt == 1 && hold_left > 0) hold_left--;
         else if (inj_dyumi && wnr && wcnt >= 3) begin dyumi = 1; inj_dyumi = 0; end
         else if (int'($urandom_range(99, 0)) < yumi_pct) begin yumi = 1; dyumi = wnr; end
      end
      pick = -1;
      if (order_mode == 0) begin
         if (pend.size() > 0 && pend[0].due <= cyc) pick = 0;
      end else if (order_mode == 2) begin
         for (int i = pend.size() - 1; i >= 0 && pick < 0; i--) if (pend[i].due <= cyc) pick = i;
      end else begin
         ndue = 0;
         foreach (pend[i]) if (pend[i].due <= cyc) ndue++;
         if (ndue > 0) begin
            sel = int'($urandom_range(ndue - 1, 0));
            foreach (pend[i]) if (pend[i].due <= cyc) begin
               if (sel == 0 && pick < 0) pick = i;
               sel--;
            end
         end
      end
      if (pick >= 0) begin
         rv = 1;
         raddr = pend[pick].a;
         rdata = mem.exists(raddr) ? mem[raddr] : pat(raddr);
         if (corrupt_next) begin rdata[7] = ~rdata[7]; corrupt_next = 0; end
         pend.delete(pick);
      end
   end

   task automatic pulse_start();
      @(posedge clk); #1 start = 1;
      @(posedge clk); #1 start = 0;
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (!done && n < 3000) begin @(negedge clk); n++; end
      check(name, done, 1);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("reset mask_o", mask, 8'hff);
      check("reset write_count_o", wcnt, 0);
      @(posedge clk); #2 reset_n = 1;

      // A: always-accept, in-order, latency 1
      pulse_start();
      @(negedge clk);
      check("A first addr", addr, 8'h40);
      check("A first data", wdata, 64'h5a5a0041_5a5a0040);
      wait_done("A done");
      check("A writes", wcnt, 12);
      check("A reads", rcnt, 12);
      check("A errors", ecnt, 0);

      // B: random accept/latency/order, 5-cycle hold on 2nd write, one data_yumi-only
      yumi_pct = 60; lat_min = 1; lat_max = 8; order_mode = 1;
      hold_mode = 1; hold_left = 5; inj_dyumi = 1;
      pulse_start();
      for (int n = 0; n < 200 && wcnt != 1; n++) @(negedge clk);
      check("B reached 2nd write", wcnt, 1);
      for (int i = 0; i < 5; i++) begin
         check("B held addr", addr, 8'h60);
         check("B held data", wdata, 64'h5a5a0061_5a5a0060);
         @(negedge clk);
      end
      hold_mode = 0;
      for (int n = 0; n < 300 && wcnt < 5; n++) @(negedge clk);
      pulse_start();
      wait_done("B done");
      check("B errors", ecnt, 1);
      check("B error_o", err, 1);

      // C: responses returned newest-first
      yumi_pct = 100; lat_min = 6; lat_max = 6; order_mode = 2;
      pulse_start();
      wait_done("C done");
      check("C errors", ecnt, 0);
      check("C reads", rcnt, 12);

      // D: one corrupted response, then a stray yumi while idle in done
      lat_min = 2; lat_max = 2; order_mode = 0; corrupt_next = 1;
      pulse_start();
      wait_done("D done");
      check("D errors", ecnt, 1);
      check("D error_o", err, 1);
      inj_yumi = 1;
      repeat (3) @(negedge clk);
      check("D stray yumi errors", ecnt, 2);
      check("D still done", done, 1);

      // E: reset with 3 reads in flight; stale returns must not count
      lat_min = 20; lat_max = 20;
      pulse_start();
      for (int n = 0; n < 300 && m_out != 3; n++) @(negedge clk);
      check("E reached 3 outstanding", m_out, 3);
      @(posedge clk); #3 reset_n = 0;
      #1;
      check("E rst v_o", v, 0);
      check("E rst write_not_read_o", wnr, 0);
      check("E rst ch_addr_o", addr, 0);
      check("E rst data_o", wdata, 0);
      check("E rst data_v_o", dv, 0);
      check("E rst mask_o", mask, 8'hff);
      check("E rst write_count_o", wcnt, 0);
      check("E rst error_o", err, 0);
      @(posedge clk); #2 reset_n = 1;
      repeat (30) @(negedge clk);
      check("E idle error_o", err, 0);
      check("E idle read_count_o", rcnt, 0);
      drop_pending = 1;
      lat_min = 1; lat_max = 5; order_mode = 1;
      repeat (2) @(negedge clk);
      pulse_start();
      wait_done("E done");
      check("E errors", ecnt, 0);
      check("E reads", rcnt, 12);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
